// File: rtl/crc_chk_pkg.sv
// Shared types and constants for the CRC signature checker and the benches that
// model the CRC register feeding it.
package crc_chk_pkg;

  localparam int SIG_W_DEF = 32;

  // Taps at bits 0, 3, 10 and 15, all fed back from bit 31.
  localparam logic [31:0] CRC_POLY = 32'h0000_8409;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic [31:0] crc_step(input logic [31:0] cur, input logic din);
    logic fb;
    fb = cur[31] ^ din;
    crc_step = {cur[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/crc_sig_piso.sv
// Parallel-load signature holder that unloads one bit per valid/ready handshake,
// MSB first. The bit index only moves on a handshake, so a stall never drops or repeats a bit.
module crc_sig_piso #(
  parameter int SIG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SIG_W-1:0] par_in,
  input  logic             active,
  input  logic             so_ready,
  output logic             so_data,
  output logic             so_valid,
  output logic             last,
  output logic             fire
);

  localparam int IDX_W = $clog2(SIG_W);

  logic [SIG_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign so_valid = active;
  assign fire     = active & so_ready;
  assign last     = (idx_q == '0);
  assign so_data  = active & snap_q[idx_q];

  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    if (load) begin
      snap_d = par_in;
      idx_d  = IDX_W'(SIG_W - 1);
    end else if (fire && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
      idx_q  <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/crc_signature_checker.sv
// Runs one compaction session, snapshots the CRC signature, compares it with the
// golden value and unloads the snapshot serially through crc_sig_piso.
module crc_signature_checker
  import crc_chk_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [SIG_W-1:0] crc_in,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             crc_en,
  output logic             done,
  output logic             pass,
  output logic             so_data,
  output logic             so_valid,
  input  logic             so_ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic             pass_q, pass_d;
  logic             piso_load, piso_last, piso_fire;

  // Every status output is a decode of the registered state, never of an input.
  assign busy   = (state_q == ST_RUN) || (state_q == ST_CHECK) || (state_q == ST_UNLOAD);
  assign crc_en = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign pass   = pass_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gold_d    = gold_q;
    pass_d    = pass_q;
    piso_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          gold_d  = golden;
          cnt_d   = num_cycles;
          pass_d  = 1'b0;
          state_d = (num_cycles != '0) ? ST_RUN : ST_CHECK;
        end
      end
      ST_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        piso_load = 1'b1;
        pass_d    = (crc_in == gold_q);
        state_d   = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (piso_fire && piso_last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
    end
  end

  crc_sig_piso #(
    .SIG_W(SIG_W)
  ) u_piso (
    .clk     (CK),
    .reset   (RESET),
    .load    (piso_load),
    .par_in  (crc_in),
    .active  (state_q == ST_UNLOAD),
    .so_ready(so_ready),
    .so_data (so_data),
    .so_valid(so_valid),
    .last    (piso_last),
    .fire    (piso_fire)
  );

endmodule

// File: tb/tb_crc_signature_checker.sv
// Scoreboard bench for crc_signature_checker: sessions push expected bits, pass
// and crc_en counts; a negedge monitor pops and compares as the DUT presents them.
module tb_crc_signature_checker;
  import crc_chk_pkg::*;

  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  logic             CK = 1'b0;
  logic             RESET;
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic [SIG_W-1:0] crc_in;
  logic [SIG_W-1:0] golden;
  logic             busy, crc_en, done, pass, so_data, so_valid;
  logic             so_ready;

  int errors = 0;
  int checks = 0;

  logic exp_bits[$];
  logic exp_pass[$];
  int   exp_cycles[$];

  int               en_cnt     = 0;
  int               beat_cnt   = 0;
  logic             done_prev  = 1'b0;
  logic             stall_prev = 1'b0;
  logic             data_prev  = 1'b0;
  logic [SIG_W-1:0] crc_target = '0;
  logic [SIG_W-1:0] noise      = 32'h1234_5678;

  always #5 CK = ~CK;

  crc_signature_checker #(
    .SIG_W(SIG_W),
    .CNT_W(CNT_W)
  ) dut (
    .CK        (CK),
    .RESET     (RESET),
    .start     (start),
    .num_cycles(num_cycles),
    .crc_in    (crc_in),
    .golden    (golden),
    .busy      (busy),
    .crc_en    (crc_en),
    .done      (done),
    .pass      (pass),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .so_ready  (so_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // crc_in carries the target only while neither compacting nor unloading,
  // so a snapshot taken in the wrong state picks up noise.
  always @(negedge CK) begin
    noise  = crc_step(noise, noise[7]);
    crc_in = (crc_en || so_valid) ? noise : crc_target;
    if (crc_en) en_cnt++;
    if (stall_prev && so_valid) checkOutput("stall_hold", so_data, data_prev);
    if (so_valid && so_ready) begin
      beat_cnt++;
      checkOutput("beat_queued", exp_bits.size() > 0, 1);
      if (exp_bits.size() > 0) checkOutput("so_data", so_data, exp_bits.pop_front());
    end
    stall_prev = so_valid && !so_ready;
    data_prev  = so_data;
    if (done && !done_prev) begin
      checkOutput("pass_queued", exp_pass.size() > 0, 1);
      if (exp_pass.size() > 0) checkOutput("pass", pass, exp_pass.pop_front());
      if (exp_cycles.size() > 0) checkOutput("crc_en_cycles", en_cnt, exp_cycles.pop_front());
      checkOutput("beats", beat_cnt, SIG_W);
      checkOutput("done_quiet", {busy, so_valid, crc_en}, 0);
      en_cnt   = 0;
      beat_cnt = 0;
    end
    done_prev = done;
  end

  task automatic applyReset(input logic with_start);
    RESET = 1'b1;
    start = with_start;
    @(posedge CK);
    #1;
    RESET = 1'b0;
    start = 1'b0;
    exp_bits.delete();
    exp_pass.delete();
    exp_cycles.delete();
    en_cnt     = 0;
    beat_cnt   = 0;
    stall_prev = 1'b0;
    checkOutput("reset_outputs", {busy, crc_en, done, pass, so_data, so_valid}, 0);
    @(posedge CK);
    #1;
    checkOutput("idle_after_reset", {busy, done}, 0);
  endtask

  task automatic launch(input int ncyc, input logic [SIG_W-1:0] target, input logic [SIG_W-1:0] gold);
    crc_target = target;
    num_cycles = CNT_W'(ncyc);
    golden     = gold;
    exp_cycles.push_back(ncyc);
    exp_pass.push_back(target == gold);
    for (int i = SIG_W - 1; i >= 0; i--) exp_bits.push_back(target[i]);
    start = 1'b1;
    @(posedge CK);
    #1;
    start      = 1'b0;
    golden     = ~gold;
    num_cycles = '1;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_clears", {done, pass}, 0);
    checkOutput("start_crc_en", crc_en, ncyc != 0);
  endtask

  task automatic applyStimulus(input int ncyc, input logic [SIG_W-1:0] target,
                               input logic [SIG_W-1:0] gold, input logic stall, input logic poke);
    logic [3:0] pat;
    logic       got_done;
    logic       poked_unload;
    pat          = 4'b1001;
    got_done     = 1'b0;
    poked_unload = 1'b0;
    launch(ncyc, target, gold);
    for (int k = 0; k < 400; k++) begin
      so_ready = stall ? pat[k % 4] : 1'b1;
      start    = 1'b0;
      if (poke && k == 2) start = 1'b1;
      if (poke && so_valid && !poked_unload) begin
        start        = 1'b1;
        poked_unload = 1'b1;
      end
      @(posedge CK);
      #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start    = 1'b0;
    so_ready = 1'b0;
    checkOutput("session_done", got_done, 1);
    @(negedge CK);
    #1;
  endtask

  initial begin
    RESET      = 1'b1;
    start      = 1'b0;
    so_ready   = 1'b0;
    num_cycles = '0;
    golden     = '0;
    crc_in     = '0;
    applyReset(1'b0);

    applyStimulus(4, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(4, 32'hDEADBEEF, 32'hDEADBEEE, 1'b0, 1'b0);
    applyStimulus(0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);
    applyStimulus(3, 32'hA5C3_0F96, 32'hA5C3_0F96, 1'b1, 1'b0);

    // Reset in the middle of RUN.
    launch(10, 32'h1357_9BDF, 32'h0);
    repeat (3) @(posedge CK);
    #1;
    checkOutput("mid_run_en", crc_en, 1);
    applyReset(1'b0);

    // Reset in the middle of UNLOAD, after a few beats.
    launch(1, 32'hF0F0_1234, 32'hF0F0_1234);
    so_ready = 1'b1;
    for (int k = 0; k < 20 && !so_valid; k++) begin
      @(posedge CK);
      #1;
    end
    checkOutput("unload_reached", so_valid, 1);
    repeat (5) @(posedge CK);
    #1;
    so_ready = 1'b0;
    applyReset(1'b0);

    // Start coinciding with reset is lost.
    applyReset(1'b1);

    applyStimulus(5, 32'h0123_4567, 32'h0123_4567, 1'b0, 1'b0);
    applyStimulus(6, 32'h5A5A_C3C3, 32'h5A5A_C3C3, 1'b1, 1'b1);
    applyStimulus(2, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
